// File: rtl/load_store_unit_if.sv
// Bus bundle between the core's execute stage, the load/store unit and the
// single-port word memory. The slave modport is the unit's view. The master
// modport is the view of whatever drives requests and models the memory.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    // request handshake from the core
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_byte;
    logic                  req_hi;

    // completion pulse back to the core
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    // memory pins
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_w;
    logic                  mem_r;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_byte, req_hi, mem_q,
        output req_ready, resp_valid, resp_rdata, mem_data, mem_addr, mem_w, mem_r
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_byte, req_hi, mem_q,
        input  req_ready, resp_valid, resp_rdata, mem_data, mem_addr, mem_w, mem_r
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store at a time from the core and drives
// the single-port word memory. The memory reads on split edges: it latches the
// address at a rising edge with r=1 and drives q at the following falling edge.
// Every request ends with a one-cycle resp_valid pulse. All outputs are
// registered.
//
// Build option: define LSU_BYTE_ACCESS_EN to honour req_byte/req_hi. With the
// option, byte loads return the selected byte zero-extended, and byte stores
// run a read-modify-write. Without it, every access is a word access. The
// byte merge/extract logic assumes DATA_WIDTH == 16.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | req_ready=1, waiting for a request
//  RD_ADDR | mem_r=1 with the address; the memory latches it at the end edge
//  RD_DATA | memory drives q at mid-cycle; q is sampled at the end edge
//  WR      | word store, mem_w=1; the memory writes at the end edge
//  RMW_WR  | merged byte store, mem_w=1 (byte-access build only)
//  RESP    | resp_valid=1 for one cycle
module load_store_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
`ifdef LSU_BYTE_ACCESS_EN
        RMW_WR  = 3'd4,
`endif
        RESP    = 3'd5
    } state_t;

    state_t                state_q,      state_d;
    logic                  ready_q,      ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [DATA_WIDTH-1:0] mem_data_q,   mem_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic                  mem_w_q,      mem_w_d;
    logic                  mem_r_q,      mem_r_d;
    logic                  byte_req;

`ifdef LSU_BYTE_ACCESS_EN
    // These request fields are kept for the read phase of a byte access.
    logic                  we_q,    we_d;
    logic                  byte_q,  byte_d;
    logic                  hi_q,    hi_d;
    logic [7:0]            wbyte_q, wbyte_d;

    assign byte_req = bus.req_byte;
`else
    logic                  unused_byte_sel;

    assign byte_req        = 1'b0;
    assign unused_byte_sel = bus.req_byte | bus.req_hi;
`endif

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        mem_data_d   = mem_data_q;
        mem_addr_d   = mem_addr_q;
        mem_w_d      = 1'b0;
        mem_r_d      = 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
        we_d         = we_q;
        byte_d       = byte_q;
        hi_d         = hi_q;
        wbyte_d      = wbyte_q;
`endif
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid && ready_q) begin
                    ready_d    = 1'b0;
                    mem_addr_d = bus.req_addr;
`ifdef LSU_BYTE_ACCESS_EN
                    we_d       = bus.req_we;
                    byte_d     = bus.req_byte;
                    hi_d       = bus.req_hi;
                    wbyte_d    = bus.req_wdata[7:0];
`endif
                    if (bus.req_we && !byte_req) begin
                        state_d    = WR;
                        mem_data_d = bus.req_wdata;
                        mem_w_d    = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                        mem_r_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                // mem_r was high all through this cycle; it drops now.
                state_d = RD_DATA;
            end
            RD_DATA: begin
`ifdef LSU_BYTE_ACCESS_EN
                if (we_q) begin
                    state_d    = RMW_WR;
                    mem_w_d    = 1'b1;
                    mem_data_d = hi_q ? {wbyte_q, bus.mem_q[7:0]}
                                      : {bus.mem_q[15:8], wbyte_q};
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    if (!byte_q)
                        resp_rdata_d = bus.mem_q;
                    else if (hi_q)
                        resp_rdata_d = {{(DATA_WIDTH-8){1'b0}}, bus.mem_q[15:8]};
                    else
                        resp_rdata_d = {{(DATA_WIDTH-8){1'b0}}, bus.mem_q[7:0]};
                end
`else
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = bus.mem_q;
`endif
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
`ifdef LSU_BYTE_ACCESS_EN
            RMW_WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
`endif
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight access silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_w_q      <= 1'b0;
            mem_r_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            mem_data_q   <= mem_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_q      <= mem_w_d;
            mem_r_q      <= mem_r_d;
        end
    end

`ifdef LSU_BYTE_ACCESS_EN
    // Request fields kept for the byte read-modify-write path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            hi_q    <= 1'b0;
            wbyte_q <= '0;
        end else begin
            we_q    <= we_d;
            byte_q  <= byte_d;
            hi_q    <= hi_d;
            wbyte_q <= wbyte_d;
        end
    end
`endif

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_w      = mem_w_q;
    assign bus.mem_r      = mem_r_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. It contains a split-edge word memory model and a
// flat reference image of memory. The reference image gives the expected load
// data, stored words, latency and pin activity for each request.
module tb_load_store_unit;
    localparam int DW = 16;
    localparam int AW = 16;
`ifdef LSU_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // memory: write and address latch at the rising edge, q at the falling edge
    logic [15:0] mem_arr [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] lat_addr;

    always @(posedge clk) begin
        if (bus.mem_w) mem_arr[bus.mem_addr] <= bus.mem_data;
        if (bus.mem_r) lat_addr <= bus.mem_addr;
    end

    always @(negedge clk) bus.mem_q <= mem_arr[lat_addr];

    // pin-activity monitor, sampled mid-cycle
    int ncyc = 0, w_pulses = 0, r_pulses = 0, resp_cnt = 0, both_cnt = 0, long_resp = 0;
    logic prev_w = 1'b0, prev_r = 1'b0, prev_resp = 1'b0;
    int acc_q[$];

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (bus.req_valid && bus.req_ready) acc_q.push_back(ncyc);
        if (bus.mem_w && !prev_w) w_pulses <= w_pulses + 1;
        if (bus.mem_r && !prev_r) r_pulses <= r_pulses + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
        if (bus.resp_valid && prev_resp) long_resp <= long_resp + 1;
        if (bus.mem_w && bus.mem_r) both_cnt <= both_cnt + 1;
        prev_w    <= bus.mem_w;
        prev_r    <= bus.mem_r;
        prev_resp <= bus.resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic byt, input logic hi,
                         input logic [15:0] addr, input logic [15:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_hi    = hi;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // One complete request, checked against the reference image.
    task automatic do_req(input logic we, input logic byt, input logic hi,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input string tag);
        logic [15:0] old_w, exp_rd, new_w;
        int exp_lat, exp_wc, exp_rc, lat, wc, rc, n;
        bit is_byte;
        old_w   = ref_mem[addr];
        is_byte = BYTE_EN && byt;
        exp_rd  = 16'h0;
        new_w   = old_w;
        if (!we) begin
            exp_lat = 2; exp_wc = 0; exp_rc = 1;
            if (!is_byte)  exp_rd = old_w;
            else if (hi)   exp_rd = {8'h00, old_w[15:8]};
            else           exp_rd = {8'h00, old_w[7:0]};
        end else if (is_byte) begin
            exp_lat = 3; exp_wc = 1; exp_rc = 1;
            new_w = hi ? {wdata[7:0], old_w[7:0]} : {old_w[15:8], wdata[7:0]};
        end else begin
            exp_lat = 1; exp_wc = 1; exp_rc = 0;
            new_w = wdata;
        end
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        drive(we, byt, hi, addr, wdata);
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        wc  = int'(bus.mem_w);
        rc  = int'(bus.mem_r);
        lat = 0;
        while (!bus.resp_valid && lat < 8) begin
            tick();
            lat++;
            wc += int'(bus.mem_w);
            rc += int'(bus.mem_r);
        end
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(exp_rd));
        chk({tag, "_wcyc"},  32'(wc), 32'(exp_wc));
        chk({tag, "_rcyc"},  32'(rc), 32'(exp_rc));
        tick();
        chk({tag, "_resp1"},  32'(bus.resp_valid), 32'd0);
        chk({tag, "_ready1"}, 32'(bus.req_ready), 32'd1);
        ref_mem[addr] = new_w;
        if (we) chk({tag, "_mem"}, 32'(mem_arr[addr]), 32'(new_w));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_outs"}, {26'd0, bus.resp_valid, bus.mem_w, bus.mem_r, 3'd0}, 32'd0);
        chk({tag, "_rdata"}, 32'(bus.resp_rdata), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mdata"}, 32'(bus.mem_data), 32'd0);
    endtask

    initial begin
        logic [15:0] pool [6];
        int w0, r0, rs0, bad;
        for (int i = 0; i < 65536; i++) begin
            mem_arr[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        lat_addr      = 16'h0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_hi    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        tick();
        tick();
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // word store then load
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, "st10");
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, "ld10");

        // byte path (word semantics when byte access is not built)
        do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234, "st20");
        do_req(1'b1, 1'b1, 1'b1, 16'h0020, 16'h00AB, "sbhi20");
`ifdef LSU_BYTE_ACCESS_EN
        chk("mem20_ab34", 32'(mem_arr[16'h0020]), 32'h0000AB34);
`endif
        do_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, "lbhi20");
        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, "lblo20");

        // top of the address range
        do_req(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF, "stffff");
        do_req(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, "ldffff");

        // request held valid: one load accepted every 4 clocks
        acc_q.delete();
        r0  = r_pulses;
        rs0 = resp_cnt;
        drive(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        repeat (12) tick();
        bus.req_valid = 1'b0;
        repeat (8) tick();
        chk("hold_accepts", 32'(acc_q.size()), 32'd3);
        chk("hold_gap1", 32'(acc_q.size() >= 3 ? acc_q[1] - acc_q[0] : -1), 32'd4);
        chk("hold_gap2", 32'(acc_q.size() >= 3 ? acc_q[2] - acc_q[1] : -1), 32'd4);
        chk("hold_rseq", 32'(r_pulses - r0), 32'd3);
        chk("hold_resps", 32'(resp_cnt - rs0), 32'd3);

        // reset in the middle of a load
        rs0 = resp_cnt;
        drive(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        chk("midrst_noresp", 32'(resp_cnt - rs0), 32'd0);
        do_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h4242, "afterrst");

        // reset during the read phase of a byte store: no write, no response
        do_req(1'b1, 1'b0, 1'b0, 16'h0030, 16'h5A5A, "st30");
        w0  = w_pulses;
        rs0 = resp_cnt;
        drive(1'b1, 1'b1, 1'b1, 16'h0030, 16'h00CC);
        tick();
        bus.req_valid = 1'b0;
        if (BYTE_EN) tick();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rmwrst_memw", 32'(bus.mem_w), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rmwrst_wpulse", 32'(w_pulses - w0), 32'd0);
        chk("rmwrst_resp", 32'(resp_cnt - rs0), 32'd0);
        chk("rmwrst_mem", 32'(mem_arr[16'h0030]), 32'(ref_mem[16'h0030]));

        // randomized traffic over a small address pool
        pool[0] = 16'h0000; pool[1] = 16'h0010; pool[2] = 16'h0020;
        pool[3] = 16'h0030; pool[4] = 16'hFFFF; pool[5] = 16'h7FFE;
        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                   16'($urandom), "rnd");
        end

        // whole memory against the reference image
        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem_arr[i] !== ref_mem[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);
        chk("w_r_exclusive", 32'(both_cnt), 32'd0);
        chk("resp_one_cycle", 32'(long_resp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the core: accepts load/store requests over a valid/ready handshake and drives the single-port word memory's `data`/`addr`/`w`/`r` pins. It sequences the memory's split-edge read: address is latched at posedge, data is driven at the following negedge, and it returns read data through a one-cycle response pulse. It sits between the core's execute stage and the memory instance, and optionally adds byte loads/stores via read-modify-write.

## Interface
- `DATA_WIDTH`, 16, memory word width; must be 16 when byte access is compiled in
- `ADDR_WIDTH`, 16, word-address width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: unit can accept; a request is accepted on a rising edge with `req_valid && req_ready`
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in ADDR_WIDTH: word address
- `req_wdata` in DATA_WIDTH: store data; byte stores use bits [7:0]
- `req_byte` in 1: byte access (see Configuration)
- `req_hi` in 1: byte select; 1 = bits [15:8], 0 = bits [7:0]
- `resp_valid` out 1: one-cycle completion pulse for every request
- `resp_rdata` out DATA_WIDTH: load data while `resp_valid`=1; 0 for stores
- `mem_data` out DATA_WIDTH: to memory `data`
- `mem_addr` out ADDR_WIDTH: to memory `addr`
- `mem_w` out 1: to memory `w`
- `mem_r` out 1: to memory `r`
- `mem_q` in DATA_WIDTH: from memory `q`

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, RMW_WR, RESP. All outputs are registered.
- IDLE: `req_ready`=1. On acceptance, request fields are latched and `mem_addr` is loaded.
  - Word store: goes to WR with `mem_data`=`req_wdata` and `mem_w`=1.
  - Load or byte store: goes to RD_ADDR with `mem_r`=1.
- RD_ADDR goes to RD_DATA. `mem_addr` and `mem_r`=1 are held so the memory latches the address at the RD_ADDR-ending edge and drives `q` at the following negedge.
- RD_DATA: samples `mem_q` at its ending edge. `mem_r` drops.
  - Load: goes to RESP with `resp_rdata` = word, or the zero-extended selected byte for byte loads.
  - Byte store: goes to RMW_WR with `mem_data` = `mem_q` with the selected byte replaced by `req_wdata[7:0]`, and `mem_w`=1.
- WR/RMW_WR: the memory writes at the ending edge. Then `mem_w` drops and the unit goes to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- `mem_w` and `mem_r` are never both 1. `mem_addr`/`mem_data` hold their last values when idle.
- `req_ready`=0 in every state except IDLE. `req_valid` asserted while busy is ignored and not queued.
- Reset: all outputs asynchronously go to 0 except `req_ready`=1; state goes to IDLE. In-flight requests are dropped with no `resp_valid`. A `mem_w` cleared by reset before the write edge causes no write.
- Full address range 0..2**ADDR_WIDTH-1 is valid. Addresses are never incremented, so there is no wrap.

## Timing
- Latency is counted from acceptance edge E0 to the edge at which `resp_valid` rises:
  - word store: 1 clock
  - load: 2 clocks
  - byte store: 3 clocks
- Every `resp_valid` pulse lasts exactly one cycle. `req_ready` returns to 1 one clock after `resp_valid` rises.
- Throughput: word store 1 per 3 clocks, load 1 per 4 clocks, byte store 1 per 5 clocks.
- `mem_q` is sampled only at the RD_DATA-ending rising edge, a half cycle after the memory's negedge update.

## Configuration
- `LSU_BYTE_ACCESS_EN`
  - Defined: `req_byte`/`req_hi` are honoured. Byte loads return the selected byte zero-extended. Byte stores perform read-modify-write through RD_ADDR, RD_DATA, RMW_WR. RMW_WR exists only in this build.
  - Undefined: `req_byte` and `req_hi` are ports but ignored. All accesses are word accesses, and RMW_WR plus the merge/extract logic are not built.

## Test plan
- Reset: assert `rst_n`=0 mid-run -> all outputs 0, `req_ready`=1, state IDLE; release -> first request accepted next edge.
- Word store 0x1234 to 0x0010, then load 0x0010:
  - store `resp_valid` 1 clock after accept, `mem_w` high exactly one cycle
  - load `resp_valid` 2 clocks after accept with `resp_rdata`=0x1234
- Byte path (`LSU_BYTE_ACCESS_EN`): word 0x1234 at 0x0020; byte store hi 0xAB -> memory 0xAB34, `resp_valid` 3 clocks after accept; byte load hi -> 0x00AB, byte load lo -> 0x0034.
- `req_valid` held high for 10 cycles with a load -> exactly one `mem_r` sequence per accepted request, `req_ready`=0 between acceptances, accepts spaced 4 clocks apart.
- Address 0xFFFF: store 0xBEEF then load -> 0xBEEF, `mem_addr`=0xFFFF, no other location modified.
- Reset during RD_DATA of a byte store -> no `mem_w` pulse, no `resp_valid`, memory word unchanged.
